// File: rtl/adc_capture.sv
// adc_capture
// Burst capture buffer for packed ADC I/Q words. An arm pulse in IDLE
// latches a burst length, the next L framed words are written into on-chip
// RAM, and then the words are drained in order over a valid/ready stream
// with out_last marking the final word.
//
// Ports:
//   rx_clk     sole clock, rising edge
//   rx_rst     synchronous active-high reset
//   adc_data   packed {I[15:0], Q[15:0]} sample, stored verbatim
//   adc_frame  qualifier, adc_data valid when high
//   arm        start-capture pulse, honoured only in IDLE
//   cap_len    burst length sampled with arm (0 or > depth means full depth)
//   out_data   drained word
//   out_valid  out_data valid
//   out_ready  consumer accepts; transfer when out_valid && out_ready
//   out_last   high with the final word of the burst
//   busy       high while capturing or draining
//   done       one-cycle pulse after the final word transfers
module adc_capture #(
  parameter int ADDR_W = 9
) (
  input  logic              rx_clk,
  input  logic              rx_rst,
  input  logic [31:0]       adc_data,
  input  logic              adc_frame,
  input  logic              arm,
  input  logic [ADDR_W:0]   cap_len,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [31:0]     mem [0:(1 << ADDR_W) - 1];

  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] len_eff;
  logic [ADDR_W:0] wr_cnt;
  logic [ADDR_W:0] rd_cnt;

  // RAM read stage: ram_q is valid the cycle after a read is issued
  logic [31:0]     ram_q;
  logic            ram_vld;
  logic            ram_last;

  // Skid slot behind the output register
  logic [31:0]     skid_data;
  logic            skid_vld;
  logic            skid_last;

  logic            arm_ok;
  logic            wr_en;
  logic            wr_last;
  logic            rd_en;
  logic            xfer;
  logic            xfer_last;
  logic [1:0]      held;

  assign arm_ok    = (state == IDLE) && arm;
  assign len_eff   = ((cap_len == '0) || (cap_len > DEPTH)) ? DEPTH : cap_len;
  assign wr_en     = (state == CAPTURE) && adc_frame;
  assign wr_last   = wr_en && ((wr_cnt + CNT_ONE) == len_q);
  assign xfer      = out_valid && out_ready;
  assign xfer_last = xfer && out_last;

  // Words that will still sit in the output/skid registers after this edge.
  // A new read is only launched when its data is guaranteed a free slot when
  // it emerges, even if the consumer stalls on the next cycle.
  assign held  = {1'b0, out_valid} + {1'b0, skid_vld} + {1'b0, ram_vld}
               - {1'b0, xfer};
  assign rd_en = (state == DRAIN) && (rd_cnt != len_q) && (held < 2'd2);

  // State register
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and busy flag
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_next = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (wr_last) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (xfer_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer RAM: synchronous write while capturing, synchronous read while
  // draining. No reset so it maps onto block RAM.
  always_ff @(posedge rx_clk) begin
    if (wr_en) mem[wr_cnt[ADDR_W-1:0]] <= adc_data;
    if (rd_en) ram_q <= mem[rd_cnt[ADDR_W-1:0]];
  end

  // Counters, read pipeline flags, and the output/skid registers. The
  // output register is refilled from the skid slot first so words stay in
  // order; the skid slot only fills while the output register is stalled.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      len_q     <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      ram_vld   <= 1'b0;
      ram_last  <= 1'b0;
      skid_data <= '0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= xfer_last;

      if (arm_ok) begin
        len_q  <= len_eff;
        wr_cnt <= '0;
        rd_cnt <= '0;
      end

      if (wr_en) wr_cnt <= wr_cnt + CNT_ONE;
      if (rd_en) rd_cnt <= rd_cnt + CNT_ONE;

      ram_vld  <= rd_en;
      ram_last <= rd_en && (rd_cnt == (len_q - CNT_ONE));

      if (!out_valid || xfer) begin
        if (skid_vld) begin
          out_data  <= skid_data;
          out_last  <= skid_last;
          out_valid <= 1'b1;
          skid_vld  <= ram_vld;
          skid_data <= ram_q;
          skid_last <= ram_last;
        end else if (ram_vld) begin
          out_data  <= ram_q;
          out_last  <= ram_last;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end else if (ram_vld) begin
        skid_vld  <= 1'b1;
        skid_data <= ram_q;
        skid_last <= ram_last;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture
// Self-checking bench for adc_capture with a 16-word buffer. A table of
// bursts (length, data pattern, frame spacing, consumer duty) is run one
// after another; each burst is checked cycle by cycle for busy/done timing,
// first-valid latency, word order and out_last, and stream stability while
// stalled. A hand-written sequence covers reset in the middle of a drain.
module tb_adc_capture;

  localparam int ADDR_W = 4;
  localparam int BUDGET = 300;
  localparam int NV     = 9;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic [31:0] adc_data;
  logic        adc_frame;
  logic        arm;
  logic [4:0]  cap_len;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  int total_checks = 0;
  int pass_checks  = 0;

  typedef struct {
    logic [4:0]  cap_len;
    int          exp_len;
    logic [31:0] base;
    logic [31:0] step;
    int          gap;
    int          ready_pct;
    bit          frame_on_arm;
    bit          stray;
    logic [4:0]  stray_len;
    bit          chain;
  } vec_t;

  vec_t tbl [NV];

  adc_capture #(.ADDR_W(ADDR_W)) dut (
    .rx_clk    (rx_clk),
    .rx_rst    (rx_rst),
    .adc_data  (adc_data),
    .adc_frame (adc_frame),
    .arm       (arm),
    .cap_len   (cap_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 rx_clk = ~rx_clk;

  // Drive all DUT inputs for the coming cycle
  task automatic applyStimulus(input logic a, input logic [4:0] len,
                               input logic f, input logic [31:0] d,
                               input logic rdy);
    arm       = a;
    cap_len   = len;
    adc_frame = f;
    adc_data  = d;
    out_ready = rdy;
  endtask

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total_checks++;
    if (act === exp) begin
      pass_checks++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Run one burst cycle by cycle. Inputs are driven and outputs sampled on
  // the falling edge; a word transfers on the following rising edge when the
  // sampled out_valid meets the out_ready driven here.
  task automatic run_burst(input vec_t v, input bit pre_armed,
                           input logic [4:0] next_len);
    int          start, frames_sent, rx_cnt, lth_n, first_n, last_n;
    bit          s_valid, s_last, s_busy, s_done;
    bit          prev_valid, prev_ready, prev_last, rdy, stray_cap, stray_drn;
    bit          finished, a, f;
    logic [31:0] s_data, prev_data, d;
    logic [4:0]  len;

    start       = pre_armed ? 0 : 1;
    frames_sent = 0;
    rx_cnt      = 0;
    lth_n       = -1;
    first_n     = -1;
    last_n      = -1;
    prev_valid  = 1'b0;
    prev_ready  = 1'b0;
    prev_last   = 1'b0;
    prev_data   = '0;
    stray_cap   = 1'b0;
    stray_drn   = 1'b0;
    finished    = 1'b0;

    for (int n = 0; n < BUDGET && !finished; n++) begin
      @(negedge rx_clk);
      s_valid = out_valid;
      s_data  = out_data;
      s_last  = out_last;
      s_busy  = busy;
      s_done  = done;

      if (last_n >= 0 && n == last_n + 1) begin
        checkOutput("done pulse", 32'(s_done), 32'd1);
        checkOutput("busy after done", 32'(s_busy), 32'd0);
        checkOutput("valid after done", 32'(s_valid), 32'd0);
        if (v.chain) applyStimulus(1'b1, next_len, 1'b0, 32'h0, 1'b0);
        else         applyStimulus(1'b0, v.cap_len, 1'b0, 32'h0, 1'b0);
        finished = 1'b1;
      end else begin
        checkOutput("done low", 32'(s_done), 32'd0);
        checkOutput("busy", 32'(s_busy), 32'(n >= start));

        if (prev_valid && !prev_ready) begin
          checkOutput("stall valid", 32'(s_valid), 32'd1);
          checkOutput("stall data", s_data, prev_data);
          checkOutput("stall last", 32'(s_last), 32'(prev_last));
        end

        if (s_valid && first_n < 0) begin
          first_n = n;
          checkOutput("first valid cycle", n, lth_n + 3);
        end

        a   = 1'b0;
        f   = 1'b0;
        d   = {16'hBAD0, 16'(n)};
        len = v.cap_len;
        if (n == 0 && !pre_armed) begin
          a = 1'b1;
          if (v.frame_on_arm) begin
            f = 1'b1;
            d = 32'hDEADBEEF;
          end
        end else begin
          if (n >= start && frames_sent < v.exp_len + 3 &&
              ((n - start) % v.gap) == 0) begin
            f = 1'b1;
            if (frames_sent < v.exp_len)
              d = v.base + v.step * 32'(frames_sent);
            else
              d = 32'hEEEE0000 + 32'(frames_sent);
            if (frames_sent == v.exp_len - 1) lth_n = n;
            frames_sent++;
          end
          if (v.stray && !stray_cap && lth_n < 0 && frames_sent >= 2) begin
            a         = 1'b1;
            len       = v.stray_len;
            stray_cap = 1'b1;
          end
          if (v.stray && !stray_drn && rx_cnt == 1) begin
            a         = 1'b1;
            len       = v.stray_len;
            stray_drn = 1'b1;
          end
        end

        if (v.ready_pct >= 100) rdy = 1'b1;
        else rdy = (int'($urandom_range(99)) < v.ready_pct);

        applyStimulus(a, len, f, d, rdy);

        if (s_valid && rdy) begin
          checkOutput("word data", s_data, v.base + v.step * 32'(rx_cnt));
          checkOutput("word last", 32'(s_last), 32'(rx_cnt == v.exp_len - 1));
          if (v.ready_pct >= 100)
            checkOutput("word cycle", n, first_n + rx_cnt);
          rx_cnt++;
          if (rx_cnt == v.exp_len) last_n = n;
        end

        prev_valid = s_valid;
        prev_ready = rdy;
        prev_last  = s_last;
        prev_data  = s_data;
      end
    end

    if (!finished) begin
      total_checks++;
      $display("[TB] FAIL burst timeout: got %0d words expected %0d", rx_cnt, v.exp_len);
    end
  endtask

  initial begin
    bit          pre;
    int          got;
    logic [4:0]  nl;

    // cap_len, exp_len, base, step, gap, ready%, frame_on_arm, stray, stray_len, chain
    tbl[0] = '{5'd4,  4,  32'h00010002, 32'h00020002, 2, 100, 1'b0, 1'b0, 5'd0, 1'b0};
    tbl[1] = '{5'd0,  16, 32'h00000000, 32'h00000001, 1, 100, 1'b0, 1'b0, 5'd0, 1'b0};
    tbl[2] = '{5'd8,  8,  32'h10000000, 32'h01010101, 1, 50,  1'b0, 1'b0, 5'd0, 1'b0};
    tbl[3] = '{5'd5,  5,  32'h20000000, 32'h00000003, 3, 70,  1'b0, 1'b1, 5'd2, 1'b1};
    tbl[4] = '{5'd3,  3,  32'h30000000, 32'h00000001, 1, 100, 1'b0, 1'b0, 5'd0, 1'b0};
    tbl[5] = '{5'd1,  1,  32'h12345678, 32'h00000000, 1, 100, 1'b1, 1'b0, 5'd0, 1'b0};
    tbl[6] = '{5'd17, 16, 32'h40000000, 32'h00000011, 1, 60,  1'b0, 1'b0, 5'd0, 1'b0};
    tbl[7] = '{5'd16, 16, 32'h50000000, 32'h00000101, 2, 100, 1'b0, 1'b0, 5'd0, 1'b0};
    tbl[8] = '{5'd31, 16, 32'h60000000, 32'h00001000, 1, 100, 1'b0, 1'b0, 5'd0, 1'b0};

    rx_rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge rx_clk);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_last", 32'(out_last), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    rx_rst = 1'b0;

    pre = 1'b0;
    for (int i = 0; i < NV; i++) begin
      nl = 5'd0;
      if (i + 1 < NV) nl = tbl[i + 1].cap_len;
      run_burst(tbl[i], pre, nl);
      pre = tbl[i].chain;
    end

    // Reset partway through a six-word drain
    @(negedge rx_clk);
    applyStimulus(1'b1, 5'd6, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge rx_clk);
      applyStimulus(1'b0, 5'd6, 1'b1, 32'hA0000000 + 32'(i), 1'b0);
    end
    @(negedge rx_clk);
    applyStimulus(1'b0, 5'd6, 1'b0, 32'h0, 1'b1);
    got = 0;
    for (int n = 0; n < 40 && got < 2; n++) begin
      @(negedge rx_clk);
      if (out_valid) begin
        checkOutput("pre-reset word", out_data, 32'hA0000000 + 32'(got));
        got++;
      end
    end
    if (got < 2) begin
      total_checks++;
      $display("[TB] FAIL pre-reset drain timeout: got %0d words expected 2", got);
    end
    @(negedge rx_clk);
    rx_rst = 1'b1;
    @(negedge rx_clk);
    checkOutput("mid-drain reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid-drain reset out_last", 32'(out_last), 32'd0);
    checkOutput("mid-drain reset out_data", out_data, 32'd0);
    checkOutput("mid-drain reset busy", 32'(busy), 32'd0);
    checkOutput("mid-drain reset done", 32'(done), 32'd0);
    rx_rst = 1'b0;

    run_burst('{5'd2, 2, 32'hB0000000, 32'h00000001, 1, 100, 1'b0, 1'b0, 5'd0, 1'b0},
              1'b0, 5'd0);

    @(negedge rx_clk);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    @(negedge rx_clk);
    checkOutput("final idle valid", 32'(out_valid), 32'd0);
    checkOutput("final idle done", 32'(done), 32'd0);
    checkOutput("final idle busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
